// File: rtl/key_access_responder.sv
// Key-access responder: checks a 16-bit key per source and answers grant/deny; repeated denials start a timed lockout.
// Latency: request accepted at edge T gives rsp_valid high after edge T+1, so it is sampled high at edge T+2; at best one request every 3 cycles.
// Backpressure: req_ready is low outside IDLE, rsp_* hold until rsp_ready. Define KEY_ROTATE_EN to rotate a source's key after each grant.
module key_access_responder #(
    parameter int                KEY_W       = 16,
    parameter int                ADDR_W      = 10,
    parameter logic [KEY_W-1:0]  KEY_MEM     = 16'hA5A5,
    parameter logic [KEY_W-1:0]  KEY_REG     = 16'h3C3C,
    parameter int                MAX_FAILS   = 3,
    parameter int                LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_src,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_grant,
    output logic              rsp_src,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              locked,
    output logic [1:0]        fail_count
);

    localparam int         CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [1:0] MAX_F    = 2'(MAX_FAILS);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CHECK, RESP, LOCK} state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         fail_q, fail_d;
    logic               grant_q, grant_d;
    logic               src_q, src_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ready_q, ready_d;
    logic               vld_q, vld_d;
    logic               lock_q, lock_d;
    logic [KEY_W-1:0]   exp_mem, exp_reg;
    logic               grant_hs;

    // A granted response leaving the block; drives fail clearing and key rotation.
    assign grant_hs = (state_q == RESP) && rsp_ready && grant_q;

`ifdef KEY_ROTATE_EN
    logic [KEY_W-1:0] key_mem_q, key_mem_d, key_reg_q, key_reg_d;

    // Rotate only the key of the source that was just granted.
    always_comb begin
        key_mem_d = key_mem_q;
        key_reg_d = key_reg_q;
        if (grant_hs) begin
            if (src_q) key_reg_d = {key_reg_q[KEY_W-2:0], key_reg_q[KEY_W-1]};
            else       key_mem_d = {key_mem_q[KEY_W-2:0], key_mem_q[KEY_W-1]};
        end
    end

    // Expected-key registers, restored to the parameter values by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_mem_q <= KEY_MEM;
            key_reg_q <= KEY_REG;
        end else begin
            key_mem_q <= key_mem_d;
            key_reg_q <= key_reg_d;
        end
    end

    assign exp_mem = key_mem_q;
    assign exp_reg = key_reg_q;
`else
    assign exp_mem = KEY_MEM;
    assign exp_reg = KEY_REG;
`endif

    // Next-state and next-output logic; registered outputs follow the next state.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        grant_d = grant_q;
        src_d   = src_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    src_d   = req_src;
                    key_d   = req_key;
                    addr_d  = req_addr;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                grant_d = (key_q == (src_q ? exp_reg : exp_mem));
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (grant_q)             fail_d = 2'd0;
                    else if (fail_q != MAX_F) fail_d = fail_q + 2'd1;
                    if (fail_d == MAX_F) begin
                        state_d = LOCK;
                        cnt_d   = LOCK_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LOCK: begin
                if (cnt_q == '0) begin
                    fail_d  = 2'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        vld_d   = (state_d == RESP);
        lock_d  = (state_d == LOCK);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= 2'd0;
            grant_q <= 1'b0;
            src_q   <= 1'b0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            vld_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            vld_q   <= vld_d;
            lock_q  <= lock_d;
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = vld_q;
    assign rsp_grant  = grant_q;
    assign rsp_src    = src_q;
    assign rsp_addr   = addr_q;
    assign locked     = lock_q;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_key_access_responder.sv
// Directed bench for key_access_responder: grant, rotation, fail clear, lockout, backpressure, reset mid-lock.
// Expected values are hand-computed constants; KEY_ROTATE_EN selects the rotation expectations.
// Outputs are sampled 1 time unit after the rising edge.
module tb_key_access_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_src;
    logic [15:0] req_key;
    logic [9:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_grant;
    logic        rsp_src;
    logic [9:0]  rsp_addr;
    logic        locked;
    logic [1:0]  fail_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] mem_key;

    key_access_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_key    (req_key),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_grant  (rsp_grant),
        .rsp_src    (rsp_src),
        .rsp_addr   (rsp_addr),
        .locked     (locked),
        .fail_count (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request and wait (bounded) for it to be accepted; returns 1 unit after the accepting edge.
    task automatic send(input logic s, input logic [15:0] k, input logic [9:0] a,
                        input logic hold, input string tag);
        logic accepted;
        accepted  = 1'b0;
        req_src   = s;
        req_key   = k;
        req_addr  = a;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
            end
        end
        if (!hold) req_valid = 1'b0;
        chk({tag, ".accepted"}, {31'd0, accepted}, 32'd1);
    endtask

    // Full transaction with rsp_ready high: checks 2-cycle latency, response fields and fail_count after handshake.
    task automatic transact(input logic s, input logic [15:0] k, input logic [9:0] a,
                            input logic g, input logic [1:0] f, input string tag);
        send(s, k, a, 1'b0, tag);
        chk({tag, ".vld_chk"}, {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ".vld"},   {31'd0, rsp_valid}, 32'd1);
        chk({tag, ".grant"}, {31'd0, rsp_grant}, {31'd0, g});
        chk({tag, ".src"},   {31'd0, rsp_src},   {31'd0, s});
        chk({tag, ".addr"},  {22'd0, rsp_addr},  {22'd0, a});
        @(posedge clk); #1;
        chk({tag, ".vld_done"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, ".fail"},     {30'd0, fail_count}, {30'd0, f});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_src   = 1'b0;
        req_key   = 16'h0;
        req_addr  = 10'h0;
        rsp_ready = 1'b1;
        #2;
        // Reset state
        chk("rst.ready", {31'd0, req_ready},  32'd0);
        chk("rst.vld",   {31'd0, rsp_valid},  32'd0);
        chk("rst.grant", {31'd0, rsp_grant},  32'd0);
        chk("rst.src",   {31'd0, rsp_src},    32'd0);
        chk("rst.addr",  {22'd0, rsp_addr},   32'd0);
        chk("rst.lock",  {31'd0, locked},     32'd0);
        chk("rst.fail",  {30'd0, fail_count}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rel.ready_high", {31'd0, req_ready}, 32'd1);

        // Basic grant from memory side
        transact(1'b0, 16'hA5A5, 10'h010, 1'b1, 2'd0, "basic");
        chk("basic.ready_after", {31'd0, req_ready}, 32'd1);

        // Key rotation: A5A5 rotl1 = 4B4B, then 9696
`ifdef KEY_ROTATE_EN
        transact(1'b0, 16'hA5A5, 10'h011, 1'b0, 2'd1, "rot.old_key");
        transact(1'b0, 16'h4B4B, 10'h012, 1'b1, 2'd0, "rot.new_key");
        mem_key = 16'h9696;
`else
        transact(1'b0, 16'hA5A5, 10'h011, 1'b1, 2'd0, "rot.fixed_key");
        mem_key = 16'hA5A5;
`endif

        // Fail clear: two denials then a register-side grant
        transact(1'b1, 16'h0000, 10'h030, 1'b0, 2'd1, "fclr.d1");
        transact(1'b1, 16'h0000, 10'h031, 1'b0, 2'd2, "fclr.d2");
        transact(1'b1, 16'h3C3C, 10'h032, 1'b1, 2'd0, "fclr.grant");

        // Lockout: three denials, then 16 locked cycles with a request held off
        transact(1'b1, 16'h0000, 10'h040, 1'b0, 2'd1, "lock.d1");
        transact(1'b1, 16'h0000, 10'h041, 1'b0, 2'd2, "lock.d2");
        transact(1'b1, 16'h0000, 10'h042, 1'b0, 2'd3, "lock.d3");
        chk("lock.locked_R", {31'd0, locked},    32'd1);
        chk("lock.ready_R",  {31'd0, req_ready}, 32'd0);
        req_src   = 1'b1;
        req_key   = 16'h3C3C;
        req_addr  = 10'h077;
        req_valid = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            chk("lock.locked", {31'd0, locked},    32'd1);
            chk("lock.ready",  {31'd0, req_ready}, 32'd0);
            chk("lock.vld",    {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("lock.end_locked", {31'd0, locked},     32'd0);
        chk("lock.end_fail",   {30'd0, fail_count}, 32'd0);
        chk("lock.end_ready",  {31'd0, req_ready},  32'd1);
        @(posedge clk); #1;
        chk("lock.no_accept", {31'd0, req_ready}, 32'd1);

        // Backpressure: response held 5 cycles while a second request waits
        rsp_ready = 1'b0;
        send(1'b0, mem_key, 10'h3FF, 1'b1, "bp.first");
        req_key  = 16'h1111;
        req_addr = 10'h155;
        @(posedge clk); #1;
        chk("bp.vld_first", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.vld",   {31'd0, rsp_valid}, 32'd1);
            chk("bp.grant", {31'd0, rsp_grant}, 32'd1);
            chk("bp.addr",  {22'd0, rsp_addr},  32'h3FF);
            chk("bp.ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.hs_vld",   {31'd0, rsp_valid},  32'd0);
        chk("bp.hs_ready", {31'd0, req_ready},  32'd1);
        chk("bp.hs_fail",  {30'd0, fail_count}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp.second_accepted", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("bp.second_vld",   {31'd0, rsp_valid}, 32'd1);
        chk("bp.second_addr",  {22'd0, rsp_addr},  32'h155);
        chk("bp.second_grant", {31'd0, rsp_grant}, 32'd0);
        @(posedge clk); #1;
        chk("bp.second_fail", {30'd0, fail_count}, 32'd1);

        // Reset in the middle of a lockout
        transact(1'b1, 16'h0000, 10'h050, 1'b0, 2'd2, "rlock.d2");
        transact(1'b1, 16'h0000, 10'h051, 1'b0, 2'd3, "rlock.d3");
        repeat (3) @(posedge clk);
        #1;
        chk("rlock.pre_locked", {31'd0, locked}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rlock.locked", {31'd0, locked},     32'd0);
        chk("rlock.fail",   {30'd0, fail_count}, 32'd0);
        chk("rlock.vld",    {31'd0, rsp_valid},  32'd0);
        chk("rlock.ready",  {31'd0, req_ready},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Keys are back to reset values, so A5A5 is granted in either build
        transact(1'b0, 16'hA5A5, 10'h0AA, 1'b1, 2'd0, "rlock.after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
